// File: rtl/blk_mem_pipe_wrapper.sv
// rtl/blk_mem_pipe_wrapper.sv - pipelined block RAM with credit-gated in-order read response FIFO
module blk_mem_pipe_wrapper #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 2,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    arstz_aq,
    input  logic                    req_en,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_din,
    output logic                    req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dout,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(NB);
    localparam int WW    = ADDR_WIDTH - OFS;
    localparam int WORDS = 1 << WW;
    localparam int CW    = $clog2(OUT_DEPTH + 1);
    localparam int PW    = $clog2(OUT_DEPTH) + 1;
    localparam int IW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    // Storage: RAM array, read data pipeline and response FIFO array carry no reset.
    logic [DATA_WIDTH-1:0]   mem [WORDS];
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   fifo_mem [OUT_DEPTH];

    // Control state, asynchronously reset.
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           credit_q, credit_d;
    logic [DATA_WIDTH-1:0]   rsp_dout_q, rsp_dout_d;

    logic [WW-1:0]           word_idx;
    logic [IW-1:0]           wr_idx;
    logic [IW-1:0]           rd_idx;
    logic                    wr_en;
    logic                    rd_accept;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;

    assign word_idx   = req_addr[ADDR_WIDTH-1:OFS];
    assign wr_en      = req_en & req_we;
    assign rd_accept  = req_en & ~req_we & req_ready;

    // Sub-word byte offset bits do not select anything in a word-wide RAM.
    if (OFS > 0) begin : g_addr_lsb
        logic unused_addr_lsb;
        assign unused_addr_lsb = ^req_addr[OFS-1:0];
    end

    // The oldest pipeline stage lands in the FIFO; ordering is preserved end to end.
    assign push       = vld_q[READ_LATENCY-1];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == PW'(OUT_DEPTH));
    assign wr_idx     = IW'(wr_ptr_q % PW'(OUT_DEPTH));
    assign rd_idx     = IW'(rd_ptr_q % PW'(OUT_DEPTH));

    assign rsp_valid  = ~fifo_empty;
    assign pop        = rsp_valid & rsp_ready;
    // Head of FIFO when occupied, otherwise the last word handed to the consumer.
    assign rsp_dout   = fifo_empty ? rsp_dout_q : fifo_mem[rd_idx];

    // Credit covers both in-flight reads and FIFO entries, so a FIFO slot is always free.
    assign req_ready  = (credit_q < CW'(OUT_DEPTH));
    assign busy       = (credit_q != '0);

    // RAM: byte-masked write, read-first registered read, then a free-running data pipeline.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (req_wstrb[b]) begin
                    mem[word_idx][b*8 +: 8] <= req_din[b*8 +: 8];
                end
            end
        end
        pipe_data_q[0] <= mem[word_idx];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    // Response FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx] <= pipe_data_q[READ_LATENCY-1];
        end
    end

    // Next-state for the valid pipeline, FIFO pointers, credit counter and held output word.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_accept;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        credit_d = credit_q;
        if (rd_accept && !pop) begin
            credit_d = credit_q + CW'(1);
        end else if (!rd_accept && pop) begin
            credit_d = credit_q - CW'(1);
        end

        rsp_dout_d = rsp_dout_q;
        if (pop) begin
            rsp_dout_d = fifo_mem[rd_idx];
        end
    end

    // Control registers; reset discards every in-flight read and buffered response.
    always_ff @(posedge clk or negedge arstz_aq) begin
        if (!arstz_aq) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            credit_q   <= '0;
            rsp_dout_q <= '0;
        end else begin
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            credit_q   <= credit_d;
            rsp_dout_q <= rsp_dout_d;
        end
    end

    // A push into a full FIFO without a simultaneous pop would lose data.
    a_no_overflow: assert property (@(posedge clk) disable iff (!arstz_aq)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_blk_mem_pipe_wrapper.sv
// tb/tb_blk_mem_pipe_wrapper.sv - self-checking bench for blk_mem_pipe_wrapper
module tb_blk_mem_pipe_wrapper;

    localparam int L = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        arstz_aq;
    logic        req_en;
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic [11:0] req_addr;
    logic [31:0] req_din;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dout;
    logic        busy;

    always #5 clk = ~clk;

    blk_mem_pipe_wrapper #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (12),
        .READ_LATENCY (L),
        .OUT_DEPTH    (D)
    ) dut (
        .clk       (clk),
        .arstz_aq  (arstz_aq),
        .req_en    (req_en),
        .req_we    (req_we),
        .req_wstrb (req_wstrb),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dout  (rsp_dout),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] data;
        int          rdy;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem_m [1024];
    logic [31:0] last_dout;
    int          edge_cnt;
    int          cmp_cnt;
    int          err_cnt;

    function automatic logic m_valid();
        return (q.size() > 0) && (q[0].rdy <= edge_cnt);
    endfunction

    function automatic logic [31:0] m_dout();
        return m_valid() ? q[0].data : last_dout;
    endfunction

    function automatic logic m_ready();
        return q.size() < D;
    endfunction

    function automatic logic m_busy();
        return q.size() != 0;
    endfunction

    task automatic step(input logic en, input logic we, input logic [3:0] strb,
                        input logic [11:0] addr, input logic [31:0] din, input logic rr);
        logic        pop;
        logic        acc;
        logic [31:0] rd;
        rsp_t        e;
        req_en    = en;
        req_we    = we;
        req_wstrb = strb;
        req_addr  = addr;
        req_din   = din;
        rsp_ready = rr;
        pop = m_valid() && rr;
        acc = en && !we && m_ready();
        rd  = mem_m[addr[11:2]];
        if (pop) begin
            last_dout = q[0].data;
            void'(q.pop_front());
        end
        if (acc) begin
            e.data = rd;
            e.rdy  = edge_cnt + 1 + L;
            q.push_back(e);
        end
        if (en && we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem_m[addr[11:2]][b*8 +: 8] = din[b*8 +: 8];
            end
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        arstz_aq  = 1'b0;
        req_en    = 1'b0;
        req_we    = 1'b0;
        req_wstrb = 4'h0;
        req_addr  = 12'h0;
        req_din   = 32'h0;
        rsp_ready = 1'b0;
        q.delete();
        last_dout = 32'h0;
        edge_cnt  = 0;
        repeat (3) @(negedge clk);
        cmp_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        cmp_cnt++; if (rsp_dout !== 32'h0) begin err_cnt++; $display("FAIL reset_rsp_dout: got %h want 0", rsp_dout); end
        arstz_aq = 1'b1;
    endtask

    task automatic test_basic();
        step(1'b1, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF, 1'b1);
        step(1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 1'b1);
        cmp_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL basic_edge_k: got valid=%b busy=%b want valid=0 busy=1", rsp_valid, busy); end
        step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_edge_k1: got valid=%b want 0", rsp_valid); end
        step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        cmp_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_edge_k2: got valid=%b want 1", rsp_valid); end
        cmp_cnt++; if (rsp_dout !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL basic_data: got %h want deadbeef", rsp_dout); end
        step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        cmp_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL basic_after_pop: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
        cmp_cnt++; if (rsp_dout !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL basic_hold: got %h want deadbeef", rsp_dout); end
    endtask

    task automatic test_strobe();
        step(1'b1, 1'b1, 4'hF, 12'h020, 32'h11223344, 1'b1);
        step(1'b1, 1'b1, 4'b0101, 12'h020, 32'hAABBCCDD, 1'b1);
        step(1'b1, 1'b0, 4'h0, 12'h020, 32'h0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_dout !== 32'h11BB33DD) begin err_cnt++; $display("FAIL strobe_data: got valid=%b %h want 1 11bb33dd", rsp_valid, rsp_dout); end
        step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
    endtask

    task automatic test_stream();
        logic [31:0] exp [16];
        int got;
        int first;
        int last;
        got = 0; first = -1; last = -1;
        for (int i = 0; i < 16; i++) begin
            exp[i] = $urandom;
            step(1'b1, 1'b1, 4'hF, 12'(i * 4), exp[i], 1'b1);
        end
        for (int i = 0; i < 24; i++) begin
            if (rsp_valid === 1'b1 && got < 16) begin
                cmp_cnt++; if (rsp_dout !== exp[got]) begin err_cnt++; $display("FAIL stream_data[%0d]: got %h want %h", got, rsp_dout, exp[got]); end
                if (first < 0) first = i;
                last = i;
                got++;
            end
            if (i < 16) begin
                cmp_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL stream_ready[%0d]: got %b want 1", i, req_ready); end
                step(1'b1, 1'b0, 4'h0, 12'(i * 4), 32'h0, 1'b1);
            end else begin
                step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
            end
        end
        cmp_cnt++; if (got !== 16) begin err_cnt++; $display("FAIL stream_count: got %0d want 16", got); end
        cmp_cnt++; if (last - first !== 15) begin err_cnt++; $display("FAIL stream_rate: got span %0d want 15", last - first); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [4];
        for (int i = 0; i < 4; i++) exp[i] = mem_m[i];
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0, 12'(i * 4), 32'h0, 1'b0);
        cmp_cnt++; if (req_ready !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL bp_full: got ready=%b busy=%b want 0 1", req_ready, busy); end
        step(1'b1, 1'b1, 4'hF, 12'h0F0, 32'hCAFE0001, 1'b0);
        repeat (2) begin
            cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_dout !== exp[0]) begin err_cnt++; $display("FAIL bp_stable: got valid=%b %h want 1 %h", rsp_valid, rsp_dout, exp[0]); end
            step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        end
        for (int j = 0; j < 4; j++) begin
            cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_dout !== exp[j]) begin err_cnt++; $display("FAIL bp_data[%0d]: got valid=%b %h want 1 %h", j, rsp_valid, rsp_dout, exp[j]); end
            step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
            if (j == 0) begin
                cmp_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_return: got %b want 1", req_ready); end
            end
        end
        cmp_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL bp_drained: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
        step(1'b1, 1'b0, 4'h0, 12'h0F0, 32'h0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        cmp_cnt++; if (rsp_dout !== 32'hCAFE0001) begin err_cnt++; $display("FAIL bp_write_while_full: got %h want cafe0001", rsp_dout); end
        step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
    endtask

    task automatic test_read_first();
        step(1'b1, 1'b1, 4'hF, 12'h040, 32'h9, 1'b1);
        step(1'b1, 1'b0, 4'h0, 12'h040, 32'h0, 1'b1);
        step(1'b1, 1'b1, 4'hF, 12'h040, 32'h5, 1'b1);
        step(1'b1, 1'b0, 4'h0, 12'h040, 32'h0, 1'b1);
        cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_dout !== 32'h9) begin err_cnt++; $display("FAIL rf_old: got valid=%b %h want 1 9", rsp_valid, rsp_dout); end
        step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
        cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_dout !== 32'h5) begin err_cnt++; $display("FAIL rf_new: got valid=%b %h want 1 5", rsp_valid, rsp_dout); end
        step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        logic        en;
        logic        we;
        logic [3:0]  strb;
        logic [11:0] addr;
        logic [31:0] din;
        logic        rr;
        for (int n = 0; n < 408; n++) begin
            cmp_cnt++;
            if ({rsp_valid, req_ready, busy} !== {m_valid(), m_ready(), m_busy()}) begin
                err_cnt++;
                $display("FAIL rand_ctrl[%0d]: got v/r/b=%b%b%b want %b%b%b", n, rsp_valid, req_ready, busy, m_valid(), m_ready(), m_busy());
            end
            cmp_cnt++; if (rsp_dout !== m_dout()) begin err_cnt++; $display("FAIL rand_dout[%0d]: got %h want %h", n, rsp_dout, m_dout()); end
            en   = ($urandom_range(0, 3) != 0);
            we   = ($urandom_range(0, 3) == 0);
            strb = 4'($urandom);
            addr = 12'($urandom_range(0, 15) * 4);
            din  = $urandom;
            rr   = (n >= 400) || ($urandom_range(0, 2) != 0);
            if (n >= 400) en = 1'b0;
            step(en, we, strb, addr, din, rr);
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 12'(i * 4), 32'h0, 1'b0);
        cmp_cnt++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin err_cnt++; $display("FAIL mr_pre: got valid=%b busy=%b want 1 1", rsp_valid, busy); end
        req_en   = 1'b0;
        arstz_aq = 1'b0;
        #1;
        cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL mr_valid_now: got %b want 0", rsp_valid); end
        cmp_cnt++; if (busy !== 1'b0 || req_ready !== 1'b1) begin err_cnt++; $display("FAIL mr_credit: got busy=%b ready=%b want 0 1", busy, req_ready); end
        q.delete();
        last_dout = 32'h0;
        @(negedge clk);
        @(negedge clk);
        arstz_aq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1);
            cmp_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL mr_after[%0d]: got valid=%b busy=%b want 0 0", i, rsp_valid, busy); end
        end
        cmp_cnt++; if (rsp_dout !== 32'h0) begin err_cnt++; $display("FAIL mr_dout: got %h want 0", rsp_dout); end
    endtask

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_basic();
        test_strobe();
        test_stream();
        test_backpressure();
        test_read_first();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion want finish before 500000");
        $fatal(1);
    end

endmodule
